seg_scan: RTL and testbench

Time-multiplexed display driver sitting directly downstream of the 4-bit ALU front panel. It consumes the eight 7-segment patterns produced there (a-sign, a, op, b-sign, b, '=', result-sign, result) plus the co/zero/overflow flags. It drives one shared active-low segment bus with active-low digit enables and inter-digit blanking to suppress ghosting. It also latches the flags onto LEDs with a sticky overflow indicator that blinks selected digits.

---
 rtl/seg_scan.sv | 112 +++++++++++
 tb/tb_seg_scan.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit 7-segment scanner with inter-digit blanking,
// frame-synchronous shadow capture, flag LEDs and a sticky-overflow blink.
module seg_scan #(
  parameter int DIV          = 1000,
  parameter int BLANK        = 8,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [55:0] seg_in,
  input  logic [2:0]  flags_in,
  input  logic        hold,
  input  logic        load,
  input  logic        clr_ovf,
  input  logic [7:0]  blink_mask,
  output logic [6:0]  seg_out,
  output logic [7:0]  an_out,
  output logic [2:0]  led,
  output logic        ovf_sticky,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

  typedef enum logic {S_BLANK, S_SHOW} slot_e;

  logic [CW-1:0] cnt_q;
  logic [2:0]    digit_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic [6:0]    shadow_q [8];
  logic [2:0]    flags_q;
  logic          ovf_q, ovf_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          tick_q;
  logic          in_blank, boundary, capture;
  slot_e         slot;

  // A zero-length blank window must not elaborate an always-false compare.
  generate
    if (BLANK == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_END = CW'(BLANK);
      assign in_blank = (cnt_q < BLANK_END);
    end
  endgenerate

  assign boundary = (digit_q == 3'd7) && (cnt_q == CNT_MAX);
  assign capture  = load | (boundary & ~hold);
  assign ovf_d    = (capture & flags_in[2]) | (ovf_q & ~clr_ovf);

  always_comb begin
    slot  = in_blank ? S_BLANK : S_SHOW;
    seg_d = 7'h7F;
    an_d  = 8'hFF;
    if (slot == S_SHOW) begin
      an_d = ~(8'd1 << digit_q);
      if (!(blink_phase_q && ovf_q && blink_mask[digit_q]))
        seg_d = shadow_q[digit_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      digit_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      for (int k = 0; k < 8; k++) shadow_q[k] <= 7'h7F;
      flags_q       <= '0;
      ovf_q         <= 1'b0;
      seg_q         <= 7'h7F;
      an_q          <= 8'hFF;
      tick_q        <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= boundary;
      ovf_q  <= ovf_d;
      if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        digit_q <= digit_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (boundary) begin
        if (blink_cnt_q == BLK_MAX) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
      if (capture) begin
        for (int k = 0; k < 8; k++) shadow_q[k] <= seg_in[7*k +: 7];
        flags_q <= flags_in;
      end
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign led        = flags_q;
  assign ovf_sticky = ovf_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboarded bench for seg_scan: a cycle model queues the expected
// registered outputs for each edge; they are popped and compared after it.
module tb_seg_scan;
  localparam int DIV = 4;
  localparam int BLANK = 1;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [55:0] seg_in;
  logic [2:0]  flags_in;
  logic        hold, load, clr_ovf;
  logic [7:0]  blink_mask;
  logic [6:0]  seg_out;
  logic [7:0]  an_out;
  logic [2:0]  led;
  logic        ovf_sticky, frame_tick;

  seg_scan #(.DIV(DIV), .BLANK(BLANK), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .flags_in(flags_in),
    .hold(hold), .load(load), .clr_ovf(clr_ovf), .blink_mask(blink_mask),
    .seg_out(seg_out), .an_out(an_out), .led(led),
    .ovf_sticky(ovf_sticky), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] an;
    logic       tick;
    logic [2:0] led;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errs = 0;
  int   ticks;

  // reference model state
  int          m_cnt, m_digit, m_bcnt;
  logic        m_phase, m_ovf;
  logic [55:0] m_sh;
  logic [2:0]  m_flags;

  task automatic model_reset();
    m_cnt = 0; m_digit = 0; m_bcnt = 0;
    m_phase = 1'b0; m_ovf = 1'b0;
    m_sh = {8{7'h7F}};
    m_flags = 3'b000;
    exp_q.delete();
  endtask

  task automatic model_step();
    exp_t e;
    logic bnd, cap;
    bnd = (m_digit == 7) && (m_cnt == DIV - 1);
    cap = load || (bnd && !hold);
    if (m_cnt < BLANK) begin
      e.an  = 8'hFF;
      e.seg = 7'h7F;
    end else begin
      e.an = 8'hFF;
      e.an[m_digit] = 1'b0;
      e.seg = (m_phase && m_ovf && blink_mask[m_digit]) ? 7'h7F : m_sh[7*m_digit +: 7];
    end
    e.tick = bnd;
    if (cap && flags_in[2]) m_ovf = 1'b1;
    else if (clr_ovf)       m_ovf = 1'b0;
    if (cap) begin
      m_sh = seg_in;
      m_flags = flags_in;
    end
    e.led = m_flags;
    e.ovf = m_ovf;
    if (bnd) begin
      if (m_bcnt == BF - 1) begin m_bcnt = 0; m_phase = ~m_phase; end
      else m_bcnt = m_bcnt + 1;
    end
    if (m_cnt == DIV - 1) begin m_cnt = 0; m_digit = (m_digit + 1) % 8; end
    else m_cnt = m_cnt + 1;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      chk("an_out", an_out, e.an);
      chk("seg_out", {1'b0, seg_out}, {1'b0, e.seg});
      chk("frame_tick", {7'd0, frame_tick}, {7'd0, e.tick});
      chk("led", {5'd0, led}, {5'd0, e.led});
      chk("ovf_sticky", {7'd0, ovf_sticky}, {7'd0, e.ovf});
    end
    if (frame_tick) ticks++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [55:0] pat;
    bit found;
    rst_n = 1'b0; hold = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    flags_in = 3'b000; blink_mask = 8'h00;
    pat = {8{7'h7F}};
    pat[6:0] = 7'h01;
    pat[41:35] = 7'h76;
    seg_in = pat;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", an_out, 8'hFF);
    chk("rst_seg", {1'b0, seg_out}, 8'h7F);
    chk("rst_led", {5'd0, led}, 8'h00);
    chk("rst_ovf", {7'd0, ovf_sticky}, 8'h00);
    chk("rst_tick", {7'd0, frame_tick}, 8'h00);
    rst_n = 1'b1;

    // scan from reset; first capture at the first frame boundary
    ticks = 0;
    run(96);
    chk("tick_count", 8'(ticks), 8'd3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (an_out == 8'hDF) found = 1'b1;
    end
    chk("digit5_found", {7'd0, found}, 8'd1);
    chk("digit5_seg", {1'b0, seg_out}, 8'h76);

    // hold freezes the display; load tears in mid-frame
    hold = 1'b1;
    for (int k = 0; k < 8; k++) pat[7*k +: 7] = 7'(7'h10 + k);
    seg_in = pat;
    run(96);
    run(10);
    load = 1'b1;
    cycle();
    load = 1'b0;
    run(40);

    // overflow capture and blinking of digit 0
    blink_mask = 8'h01;
    flags_in = 3'b100;
    hold = 1'b0;
    run(32 * 6);
    chk("led_ovf", {5'd0, led}, 8'h04);

    // clear, then set-wins-over-clear, then clear again
    hold = 1'b1;
    clr_ovf = 1'b1;
    cycle();
    chk("ovf_cleared", {7'd0, ovf_sticky}, 8'h00);
    load = 1'b1;
    cycle();
    chk("ovf_set_wins", {7'd0, ovf_sticky}, 8'h01);
    load = 1'b0;
    flags_in = 3'b000;
    cycle();
    chk("ovf_clr_again", {7'd0, ovf_sticky}, 8'h00);
    clr_ovf = 1'b0;
    run(64);

    // asynchronous reset mid-SHOW of digit 3
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_digit == 3 && m_cnt == 2) found = 1'b1;
      else cycle();
    end
    chk("reach_digit3", {7'd0, found}, 8'd1);
    chk("digit3_an", an_out, 8'hF7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", an_out, 8'hFF);
    chk("arst_seg", {1'b0, seg_out}, 8'h7F);
    chk("arst_ovf", {7'd0, ovf_sticky}, 8'h00);
    chk("arst_led", {5'd0, led}, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold = 1'b0;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
